acq_vp_mem: RTL and testbench
=============================

# acq_vp_mem

Acquisition memory that sits behind a cern-be-vme memory sub-bus, such as the acqVP window of a register decoder. It answers the decoder's RdMem/WrMem strobes with RdDone/WrDone. It shares one single-port RAM between VME accesses and a free-running acquisition stream that fills the RAM as a circular buffer. Arbitration between the two sources is fair and bounded, and the sticky status lets software locate the newest sample.

## Interface
Parameters:
- ADDR_W, 16, word-address width; RAM depth is 2**ADDR_W words; bus address is [ADDR_W:1]
- DATA_W, 16, data width of both the bus and the acquisition stream

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- VMEAddr  in  ADDR_W  word address [ADDR_W:1]; valid in the strobe cycle
- VMERdData  out  DATA_W  read data; valid in the cycle VMERdDone=1
- VMEWrData  in  DATA_W  write data; valid in the strobe cycle
- VMERdMem  in  1  single-cycle read strobe
- VMEWrMem  in  1  single-cycle write strobe
- VMERdDone  out  1  single-cycle read completion
- VMEWrDone  out  1  single-cycle write completion
- acq_en  in  1  enables acquisition writes
- acq_clr  in  1  pulse; clears wr_ptr, wrapped and overrun
- acq_valid  in  1  sample strobe; no backpressure
- acq_data  in  DATA_W  sample value
- wr_ptr  out  ADDR_W  address the next sample will be written to
- wrapped  out  1  sticky; wr_ptr has passed the top of memory at least once
- overrun  out  1  sticky; at least one sample was dropped
- proto_err  out  1  sticky; a strobe arrived while a bus access was outstanding

## Operation
- Bus port:
  - At most one access is outstanding at a time.
  - On a strobe in IDLE, the address, data and direction are captured into a holding register.
  - A strobe arriving outside IDLE is ignored and sets proto_err.
  - If RdMem and WrMem are both high in the same cycle, the access is treated as a write and proto_err is set.
- RAM: single port, synchronous, 1-cycle read latency. One access per cycle, either a write or a read.
- Arbitration, decided per cycle:
  - A bus request that has already waited one cycle (pend_aged) wins.
  - Otherwise an acquisition write (acq_en & acq_valid) wins.
  - Otherwise a fresh bus request wins.
  - A sample that loses arbitration is dropped and sets overrun. The bus is therefore never stalled more than 1 cycle.
- Acquisition:
  - A granted sample writes acq_data at wr_ptr, then wr_ptr increments by one modulo 2**ADDR_W.
  - When wr_ptr goes from all-ones to 0, wrapped is set.
  - acq_valid is ignored while acq_en=0.
  - acq_clr has priority over a same-cycle sample: the sample is still written at the old wr_ptr, but wr_ptr ends at 0 and all flags end cleared.
- Bus writes overwrite sample data with no protection. No interaction with wr_ptr.
- FSM states:
  - IDLE: on a strobe, go to GRANT if the RAM is free this cycle, else to WAIT.
  - WAIT: pend_aged=1; go to GRANT.
  - GRANT: read → RD_DATA; write → DONE.
  - RD_DATA: capture RAM output into VMERdData; go to DONE.
  - DONE: pulse the matching Done; go to IDLE.
- Reset values:
  - VMERdData=0, VMERdDone=0, VMEWrDone=0.
  - wr_ptr=0, wrapped=0, overrun=0, proto_err=0.
  - FSM=IDLE.
  - RAM contents are not reset.
- Reset mid-access: the pending access is abandoned, no Done is emitted, and a write that has not been granted is not performed.

## Timing
- Strobe at cycle T with the RAM free:
  - Write is performed at T; VMEWrDone is high in T+1.
  - Read address is applied at T; VMERdData and VMERdDone are valid in T+2.
- Each arbitration loss adds exactly 1 cycle: write Done at T+2, read Done at T+3.
- The next strobe is accepted at the earliest in the cycle after Done.
- VMERdData holds its value until the next read completes.
- A sample granted at cycle T has its wr_ptr increment visible at T+1. Status flags are registered and update 1 cycle after the cause.

## Structure
- Package acq_vp_mem_pkg:
  - typedef enum for the FSM states (IDLE, WAIT, GRANT, RD_DATA, DONE)
  - default ADDR_W and DATA_W constants
- Sub-module acq_vp_mem_ram: single-port synchronous RAM, parameterised by ADDR_W and DATA_W, inferable as block RAM.
- Top level contains the holding register, arbiter, FSM, acquisition pointer and status flags.

## Test plan
- Bus write 0x1234 to address 0x0010 with acq idle → VMEWrDone exactly 1 cycle after the strobe. Read of 0x0010 → VMERdData=0x1234 with VMERdDone 2 cycles after the strobe.
- acq_en=1 and 5 consecutive samples 0xA0..0xA4 → wr_ptr=5. Bus reads of addresses 0..4 return 0xA0..0xA4, and overrun=0.
- Continuous acq_valid while a bus read of address 3 is issued → Done after 3 cycles, exactly one sample dropped, overrun=1, wr_ptr short by one versus the sample count.
- ADDR_W=4, 17 samples → wrapped=1, wr_ptr=1, address 0 holds the 17th sample. acq_clr then gives wr_ptr=0, wrapped=0, overrun=0.
- WrMem strobe followed by RdMem the next cycle (before Done) → second strobe ignored, proto_err=1, exactly one VMEWrDone.
- rst_n low for 1 cycle at T+1 after a read strobe → no VMERdDone, all outputs at their reset values, the next read completes normally.

Source files
------------

// File: rtl/acq_vp_mem_pkg.sv
// acq_vp_mem_pkg
//   Shared types and defaults for the acquisition memory block.
//   - DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
//   - bus_state_e             : bus-port FSM states
package acq_vp_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_GRANT   = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_DONE    = 3'd4
  } bus_state_e;

endpackage

// File: rtl/acq_vp_mem_if.sv
// acq_vp_mem_if
//   Memory sub-bus between a register decoder (master) and the acquisition
//   memory (slave).
//   Handshake: VMERdMem / VMEWrMem are single-cycle strobes that carry
//   VMEAddr (and VMEWrData for writes) in the strobe cycle. Exactly one
//   single-cycle VMERdDone / VMEWrDone answers each accepted strobe;
//   VMERdData is valid in the VMERdDone cycle. The master must not strobe
//   again until the cycle after Done.
//   Ports (master view):
//     out VMEAddr[ADDR_W:1], VMEWrData, VMERdMem, VMEWrMem
//     in  VMERdData, VMERdDone, VMEWrDone
interface acq_vp_mem_if
  import acq_vp_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W:1]   VMEAddr;
  logic [DATA_W-1:0] VMERdData;
  logic [DATA_W-1:0] VMEWrData;
  logic              VMERdMem;
  logic              VMEWrMem;
  logic              VMERdDone;
  logic              VMEWrDone;

  modport master (
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    input  VMERdData, VMERdDone, VMEWrDone
  );

  modport slave (
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    output VMERdData, VMERdDone, VMEWrDone
  );

endinterface

// File: rtl/acq_vp_mem_ram.sv
// acq_vp_mem_ram
//   Single-port synchronous RAM, one access per cycle, 1-cycle read latency
//   (read-first). Contents are not reset.
//   Ports: clk, we (write enable), addr, wd (write data), q (read data).
module acq_vp_mem_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/acq_vp_mem.sv
// acq_vp_mem
//   Acquisition memory behind a VME memory sub-bus. A free-running sample
//   stream fills the RAM as a circular buffer; bus reads/writes share the
//   same single-port RAM through a fair arbiter (an aged bus request beats
//   a sample, a sample beats a fresh bus request).
//   Ports:
//     clk, rst_n (synchronous, active-low)
//     bus        : acq_vp_mem_if slave (strobes, address, data, Done)
//     acq_en, acq_clr, acq_valid, acq_data : sample stream and clear
//     wr_ptr     : address of the next sample
//     wrapped, overrun, proto_err : sticky status
module acq_vp_mem
  import acq_vp_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  acq_vp_mem_if.slave       bus,
  input  logic              acq_en,
  input  logic              acq_clr,
  input  logic              acq_valid,
  input  logic [DATA_W-1:0] acq_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              overrun,
  output logic              proto_err
);

  bus_state_e        state;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              hold_wr;

  logic              strobe;
  logic              fresh;
  logic              pend_aged;
  logic              acq_req;
  logic              grant_bus;
  logic              grant_acq;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wd;
  logic [DATA_W-1:0] ram_q;

  // A simultaneous RdMem+WrMem is a write, so direction follows WrMem alone.
  assign strobe    = bus.VMERdMem | bus.VMEWrMem;
  assign fresh     = (state == ST_IDLE) & strobe;
  assign pend_aged = (state == ST_WAIT);
  assign acq_req   = acq_en & acq_valid;

  // The bus request drives the RAM in the cycle it wins: straight from the
  // bus pins when fresh, from the holding register once it has aged.
  assign grant_bus = pend_aged | (fresh & ~acq_req);
  assign grant_acq = acq_req & ~pend_aged;

  assign bus_wr   = pend_aged ? hold_wr   : bus.VMEWrMem;
  assign bus_addr = pend_aged ? hold_addr : bus.VMEAddr;
  assign bus_data = pend_aged ? hold_data : bus.VMEWrData;

  // No RAM write during reset so an abandoned access never lands.
  assign ram_we   = rst_n & (grant_acq | (grant_bus & bus_wr));
  assign ram_addr = grant_bus ? bus_addr : wr_ptr;
  assign ram_wd   = grant_bus ? bus_data : acq_data;

  acq_vp_mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (ram_wd),
    .q    (ram_q)
  );

  // Bus FSM. GRANT is not a resting state: the RAM is driven in the same
  // cycle the request wins (IDLE or WAIT), and the FSM moves straight on to
  // RD_DATA (read) or DONE (write). Done is high exactly while in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      hold_addr     <= '0;
      hold_data     <= '0;
      hold_wr       <= 1'b0;
      bus.VMERdData <= '0;
      bus.VMERdDone <= 1'b0;
      bus.VMEWrDone <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      bus.VMERdDone <= 1'b0;
      bus.VMEWrDone <= 1'b0;

      if (strobe && ((state != ST_IDLE) || (bus.VMERdMem && bus.VMEWrMem))) begin
        proto_err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (strobe) begin
            hold_addr <= bus.VMEAddr;
            hold_data <= bus.VMEWrData;
            hold_wr   <= bus.VMEWrMem;
            if (grant_bus) begin
              if (bus.VMEWrMem) begin
                bus.VMEWrDone <= 1'b1;
                state         <= ST_DONE;
              end else begin
                state <= ST_RD_DATA;
              end
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (hold_wr) begin
            bus.VMEWrDone <= 1'b1;
            state         <= ST_DONE;
          end else begin
            state <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          bus.VMERdData <= ram_q;
          bus.VMERdDone <= 1'b1;
          state         <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Acquisition pointer and sample status. acq_clr wins over a same-cycle
  // sample's pointer update; that sample still lands at the old wr_ptr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
      overrun <= 1'b0;
    end else if (acq_clr) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (grant_acq) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (&wr_ptr) begin
          wrapped <= 1'b1;
        end
      end
      if (acq_req && pend_aged) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acq_vp_mem.sv
// tb_acq_vp_mem
//   Directed bench for acq_vp_mem: a default-width instance (dut16) and an
//   ADDR_W=4 instance (dut4) for wrap-around. Inputs are driven 1 time unit
//   after the rising edge and outputs are sampled there as well.
module tb_acq_vp_mem;

  logic clk;
  logic rst_n;

  logic        acq_en16, acq_clr16, acq_valid16;
  logic [15:0] acq_data16;
  logic [15:0] wr_ptr16;
  logic        wrapped16, overrun16, proto_err16;

  logic        acq_en4, acq_clr4, acq_valid4;
  logic [15:0] acq_data4;
  logic [3:0]  wr_ptr4;
  logic        wrapped4, overrun4, proto_err4;

  int checks = 0;
  int errors = 0;

  acq_vp_mem_if #(.ADDR_W(16), .DATA_W(16)) bus16 ();
  acq_vp_mem_if #(.ADDR_W(4),  .DATA_W(16)) bus4 ();

  acq_vp_mem #(.ADDR_W(16), .DATA_W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus16),
    .acq_en    (acq_en16),
    .acq_clr   (acq_clr16),
    .acq_valid (acq_valid16),
    .acq_data  (acq_data16),
    .wr_ptr    (wr_ptr16),
    .wrapped   (wrapped16),
    .overrun   (overrun16),
    .proto_err (proto_err16)
  );

  acq_vp_mem #(.ADDR_W(4), .DATA_W(16)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4),
    .acq_en    (acq_en4),
    .acq_clr   (acq_clr4),
    .acq_valid (acq_valid4),
    .acq_data  (acq_data4),
    .wr_ptr    (wr_ptr4),
    .wrapped   (wrapped4),
    .overrun   (overrun4),
    .proto_err (proto_err4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input bit sel4, input logic v);
    if (sel4) acq_valid4 = v;
    else      acq_valid16 = v;
  endtask

  task automatic bump_data(input bit sel4);
    if (sel4) acq_data4 = acq_data4 + 16'd1;
    else      acq_data16 = acq_data16 + 16'd1;
  endtask

  // Bus write on dut16; Done must be high exactly 1 cycle after the strobe.
  task automatic wr16(input logic [15:0] addr, input logic [15:0] data, input string tag);
    bus16.VMEAddr   = addr;
    bus16.VMEWrData = data;
    bus16.VMEWrMem  = 1'b1;
    tick();
    bus16.VMEWrMem  = 1'b0;
    chk({tag, " wrdone"}, 32'(bus16.VMEWrDone), 32'd1);
    tick();
    chk({tag, " wrdone_low"}, 32'(bus16.VMEWrDone), 32'd0);
  endtask

  // Bus read with optional streaming samples on the same DUT. Checks the
  // strobe-to-Done latency, the data, and that Done lasts one cycle.
  task automatic rd(input bit sel4, input logic [15:0] addr, input logic [15:0] exp,
                    input int lat, input bit stream, input string tag);
    int   n;
    logic done;
    logic [15:0] d;
    if (sel4) begin
      bus4.VMEAddr  = addr[3:0];
      bus4.VMERdMem = 1'b1;
    end else begin
      bus16.VMEAddr  = addr;
      bus16.VMERdMem = 1'b1;
    end
    set_valid(sel4, stream);
    tick();
    bus4.VMERdMem  = 1'b0;
    bus16.VMERdMem = 1'b0;
    n    = 1;
    done = sel4 ? bus4.VMERdDone : bus16.VMERdDone;
    while (!done && n < 10) begin
      if (stream) bump_data(sel4);
      tick();
      n++;
      done = sel4 ? bus4.VMERdDone : bus16.VMERdDone;
    end
    set_valid(sel4, 1'b0);
    d = sel4 ? bus4.VMERdData : bus16.VMERdData;
    chk({tag, " rddone"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " rddata"}, 32'(d), 32'(exp));
    tick();
    done = sel4 ? bus4.VMERdDone : bus16.VMERdDone;
    chk({tag, " rddone_low"}, 32'(done), 32'd0);
  endtask

  // Directed sequence
  initial begin
    int wdone_cnt;
    int rdone_cnt;

    rst_n = 1'b0;
    acq_en16 = 0; acq_clr16 = 0; acq_valid16 = 0; acq_data16 = '0;
    acq_en4 = 0;  acq_clr4 = 0;  acq_valid4 = 0;  acq_data4 = '0;
    bus16.VMEAddr = '0; bus16.VMEWrData = '0; bus16.VMERdMem = 0; bus16.VMEWrMem = 0;
    bus4.VMEAddr  = '0; bus4.VMEWrData  = '0; bus4.VMERdMem  = 0; bus4.VMEWrMem  = 0;
    tick();
    tick();

    // Reset values
    chk("rst rddata",    32'(bus16.VMERdData), 32'h0);
    chk("rst rddone",    32'(bus16.VMERdDone), 32'd0);
    chk("rst wrdone",    32'(bus16.VMEWrDone), 32'd0);
    chk("rst wr_ptr",    32'(wr_ptr16), 32'd0);
    chk("rst wrapped",   32'(wrapped16), 32'd0);
    chk("rst overrun",   32'(overrun16), 32'd0);
    chk("rst proto_err", 32'(proto_err16), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain bus write then read back, acquisition idle
    wr16(16'h0010, 16'h1234, "wr10");
    rd(1'b0, 16'h0010, 16'h1234, 2, 1'b0, "rd10");

    // Five consecutive samples
    acq_en16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      acq_valid16 = 1'b1;
      acq_data16  = 16'(16'hA0 + i);
      tick();
    end
    acq_valid16 = 1'b0;
    chk("acq5 wr_ptr", 32'(wr_ptr16), 32'd5);
    for (int i = 0; i < 5; i++) begin
      rd(1'b0, 16'(i), 16'(16'hA0 + i), 2, 1'b0, $sformatf("acq5 rd%0d", i));
    end
    chk("acq5 overrun", 32'(overrun16), 32'd0);

    // Read of address 3 against a continuous stream B0, B1, B2: B1 is dropped
    acq_data16 = 16'hB0;
    rd(1'b0, 16'd3, 16'hA3, 3, 1'b1, "contend");
    chk("contend overrun", 32'(overrun16), 32'd1);
    chk("contend wr_ptr",  32'(wr_ptr16), 32'd7);
    rd(1'b0, 16'd5, 16'hB0, 2, 1'b0, "contend rd5");
    rd(1'b0, 16'd6, 16'hB2, 2, 1'b0, "contend rd6");

    // Wrap-around on the 4-bit instance: 17 samples C0..D0
    acq_en4 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      acq_valid4 = 1'b1;
      acq_data4  = 16'(16'hC0 + i);
      tick();
    end
    acq_valid4 = 1'b0;
    chk("wrap wr_ptr",  32'(wr_ptr4), 32'd1);
    chk("wrap wrapped", 32'(wrapped4), 32'd1);
    chk("wrap overrun", 32'(overrun4), 32'd0);
    rd(1'b1, 16'd15, 16'hCF, 2, 1'b0, "wrap rd15");
    acq_data4 = 16'hE0;
    rd(1'b1, 16'd0, 16'hD0, 3, 1'b1, "wrap rd0");
    chk("wrap overrun set", 32'(overrun4), 32'd1);
    acq_clr4 = 1'b1;
    tick();
    acq_clr4 = 1'b0;
    chk("clr wr_ptr",  32'(wr_ptr4), 32'd0);
    chk("clr wrapped", 32'(wrapped4), 32'd0);
    chk("clr overrun", 32'(overrun4), 32'd0);

    // WrMem followed by RdMem before Done
    chk("proto before", 32'(proto_err16), 32'd0);
    wdone_cnt = 0;
    rdone_cnt = 0;
    bus16.VMEAddr   = 16'h0020;
    bus16.VMEWrData = 16'h5555;
    bus16.VMEWrMem  = 1'b1;
    tick();
    bus16.VMEWrMem  = 1'b0;
    bus16.VMERdMem  = 1'b1;
    bus16.VMEAddr   = 16'h0010;
    if (bus16.VMEWrDone) wdone_cnt++;
    if (bus16.VMERdDone) rdone_cnt++;
    tick();
    bus16.VMERdMem  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus16.VMEWrDone) wdone_cnt++;
      if (bus16.VMERdDone) rdone_cnt++;
      tick();
    end
    chk("proto wrdone count", 32'(wdone_cnt), 32'd1);
    chk("proto rddone count", 32'(rdone_cnt), 32'd0);
    chk("proto_err set",      32'(proto_err16), 32'd1);
    rd(1'b0, 16'h0020, 16'h5555, 2, 1'b0, "proto rd20");

    // Reset in the cycle after a read strobe
    bus16.VMEAddr  = 16'h0010;
    bus16.VMERdMem = 1'b1;
    tick();
    bus16.VMERdMem = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst rddone",    32'(bus16.VMERdDone), 32'd0);
    chk("midrst wrdone",    32'(bus16.VMEWrDone), 32'd0);
    chk("midrst rddata",    32'(bus16.VMERdData), 32'h0);
    chk("midrst wr_ptr",    32'(wr_ptr16), 32'd0);
    chk("midrst wrapped",   32'(wrapped16), 32'd0);
    chk("midrst overrun",   32'(overrun16), 32'd0);
    chk("midrst proto_err", 32'(proto_err16), 32'd0);
    rdone_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus16.VMERdDone) rdone_cnt++;
    end
    chk("midrst no done", 32'(rdone_cnt), 32'd0);
    rd(1'b0, 16'h0010, 16'h1234, 2, 1'b0, "after rst rd10");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
